// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: memctrl bit positions and the data-memory FSM state type.
// Used by data_mem_ctrl and the instruction controller.
package mips_pkg;

    localparam int MC_W  = 3;
    localparam int MC_RD = 2;
    localparam int MC_WR = 1;
    localparam int MC_RW = 0;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } dmem_state_e;

    function automatic logic word_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words, write-first, one-cycle registered read.
// Contents are not reset.
module dmem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder on the memctrl interface: loads with READ_LAT latency, single-cycle stores.
// Optional feature: DMEM_ALIGN_CHECK_EN rejects accesses whose addr[1:0] is non-zero.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready high, accepting loads/stores
// RD_WAIT | load in flight; cnt_q counts remaining cycles, response at 0
module data_mem_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [MC_W-1:0] memctrl,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            ready,
    output logic [31:0]     rdata,
    output logic            rdata_valid,
    output logic            err
);

    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_lat
        $error("data_mem_ctrl: READ_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] hold_q, hold_d;

    logic              rd_cmd, wr_cmd, bad_align;
    logic              accept, rd_acc, wr_acc, rsp_now;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       ram_rdata;
    logic              unused_ok;

    assign rd_cmd    = memctrl[MC_RD];
    assign wr_cmd    = memctrl[MC_WR];
    assign word_addr = addr[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad_align = (rd_cmd | wr_cmd) & word_misaligned(addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    // Upper address bits wrap away; bit0 of memctrl is register write-back, not ours.
    assign unused_ok = ^{memctrl[MC_RW], addr[31:ADDR_W+2], addr[1:0]};

    assign rsp_now = (state_q == RD_WAIT) && (cnt_q == 4'd0);
    assign ready   = (state_q == IDLE) || rsp_now;
    assign accept  = req & ready;
    assign rd_acc  = accept & rd_cmd & ~bad_align;
    // Read+write together executes as a read only.
    assign wr_acc  = accept & wr_cmd & ~rd_cmd & ~bad_align;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (rd_acc | wr_acc),
        .we_i    (wr_acc),
        .addr_i  (word_addr),
        .wdata_i (wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    state_d = RD_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (rd_acc) begin
                    cnt_d = LAT_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign err_d  = accept & ((rd_cmd & wr_cmd) | bad_align);
    assign hold_d = rdata_valid ? ram_rdata : hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // A reset landing on the response cycle suppresses the pulse: the read is aborted.
    assign rdata_valid = rsp_now & ~reset;
    assign rdata       = rdata_valid ? ram_rdata : hold_q;
    assign err         = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (ADDR_W=8, READ_LAT=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  memctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_ctrl #(
        .ADDR_W   (8),
        .READ_LAT (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .memctrl     (memctrl),
        .addr        (addr),
        .wdata       (wdata),
        .ready       (ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        req     = 1'b1;
        memctrl = 3'b010;
        addr    = a;
        wdata   = d;
        step();
        req = 1'b0;
        check({tag, "_wr_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_wr_novalid"}, {31'd0, rdata_valid}, 32'd0);
    endtask

    // READ_LAT=2: one stall cycle, then the response cycle with ready back high.
    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req     = 1'b1;
        memctrl = 3'b100;
        addr    = a;
        step();
        req = 1'b0;
        check({tag, "_stall"}, {31'd0, ready}, 32'd0);
        check({tag, "_early"}, {31'd0, rdata_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, rdata_valid}, 32'd1);
        check({tag, "_data"}, rdata, exp);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        req     = 1'b0;
        memctrl = 3'b000;
        addr    = 32'd0;
        wdata   = 32'd0;
        step();
        step();
        reset = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_valid", {31'd0, rdata_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Store then load.
        do_write("w10", 32'h10, 32'hDEADBEEF);
        check("w10_err", {31'd0, err}, 32'd0);
        do_read("r10", 32'h10, 32'hDEADBEEF);
        step();
        check("hold_novalid", {31'd0, rdata_valid}, 32'd0);
        check("hold_rdata", rdata, 32'hDEADBEEF);

        // Back-to-back loads with req held high.
        do_write("w0", 32'h0, 32'h11111111);
        do_write("w4", 32'h4, 32'h22222222);
        req     = 1'b1;
        memctrl = 3'b100;
        addr    = 32'h0;
        step();
        check("b2b_stall", {31'd0, ready}, 32'd0);
        step();
        check("b2b_v1", {31'd0, rdata_valid}, 32'd1);
        check("b2b_d1", rdata, 32'h11111111);
        check("b2b_rdy1", {31'd0, ready}, 32'd1);
        addr = 32'h4;
        step();
        req = 1'b0;
        check("b2b_gap", {31'd0, rdata_valid}, 32'd0);
        check("b2b_stall2", {31'd0, ready}, 32'd0);
        step();
        check("b2b_v2", {31'd0, rdata_valid}, 32'd1);
        check("b2b_d2", rdata, 32'h22222222);

        // Illegal read+write: read only, err one cycle after accept.
        do_write("w20", 32'h20, 32'h00001234);
        req     = 1'b1;
        memctrl = 3'b110;
        addr    = 32'h20;
        wdata   = 32'hFFFFFFFF;
        step();
        req = 1'b0;
        check("rw_err", {31'd0, err}, 32'd1);
        check("rw_stall", {31'd0, ready}, 32'd0);
        step();
        check("rw_err_clr", {31'd0, err}, 32'd0);
        check("rw_valid", {31'd0, rdata_valid}, 32'd1);
        check("rw_data", rdata, 32'h00001234);
        step();
        do_read("rw_ram", 32'h20, 32'h00001234);

        // No-op request.
        req     = 1'b1;
        memctrl = 3'b001;
        addr    = 32'h10;
        step();
        req = 1'b0;
        check("nop_ready", {31'd0, ready}, 32'd1);
        check("nop_err", {31'd0, err}, 32'd0);
        check("nop_valid", {31'd0, rdata_valid}, 32'd0);

        // Reset while a load is in flight.
        req     = 1'b1;
        memctrl = 3'b100;
        addr    = 32'h10;
        step();
        req = 1'b0;
        check("abort_stall", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        step();
        check("abort_novalid", {31'd0, rdata_valid}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_rdata", rdata, 32'd0);
        reset = 1'b0;
        step();
        check("abort_novalid2", {31'd0, rdata_valid}, 32'd0);
        do_read("post_rst", 32'h10, 32'hDEADBEEF);

        // Address wrap: 0x400 aliases to word 0.
        do_write("w400", 32'h400, 32'hA5A5A5A5);
        do_read("alias0", 32'h0, 32'hA5A5A5A5);
        do_read("alias400", 32'h400, 32'hA5A5A5A5);

        // Misaligned store.
        do_write("w13", 32'h13, 32'hCAFEF00D);
`ifdef DMEM_ALIGN_CHECK_EN
        check("w13_err", {31'd0, err}, 32'd1);
        step();
        check("w13_err_clr", {31'd0, err}, 32'd0);
        do_read("r10_old", 32'h10, 32'hDEADBEEF);
`else
        check("w13_err", {31'd0, err}, 32'd0);
        step();
        do_read("r10_new", 32'h10, 32'hCAFEF00D);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
